// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, load-use scoreboard,
// immediate extraction and a single registered output bundle with valid/ready handshake.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            flush,
    input  logic            rf_wen,
    input  logic [AW-1:0]   rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_rdaddr,
    output logic [6:0]      out_operation,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_imm,
    output logic            out_mem_wen,
    output logic            out_mem_ren,
    output logic            out_rf_wen,
    output logic            out_illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
    } iclass_e;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sd;
        logic [XLEN-1:0] imm;
        logic            mem_wen;
        logic            mem_ren;
        logic            rf_wen;
        logic            illegal;
    } bundle_t;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic            valid_q, valid_d;
    bundle_t         bundle_q, bundle_d, new_b;

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [XLEN-1:0] imm_x, rs1_data, rs2_data;
    iclass_e         cls;
    logic            use_rs1, use_rs2, writes_rd;
    logic            hit1, hit2, hazard, capture;

    assign opcode = instruction[6:0];
    assign rd     = instruction[7 +: AW];
    assign rs1    = instruction[15 +: AW];
    assign rs2    = instruction[20 +: AW];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cls     = C_ILLEGAL;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R:     begin cls = C_R;      use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IALU:  begin cls = C_IALU;   imm32 = imm_i;  use_rs1 = 1'b1; end
            OP_LOAD:  begin cls = C_LOAD;   imm32 = imm_i;  use_rs1 = 1'b1; end
            OP_STORE: begin cls = C_STORE;  imm32 = imm_s;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BR:    begin cls = C_BRANCH; imm32 = imm_b;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LUI:   begin cls = C_LUI;    imm32 = imm_u;  end
            OP_AUIPC: begin cls = C_AUIPC;  imm32 = imm_u;  end
            OP_JAL:   begin cls = C_JAL;    imm32 = imm_j;  end
            OP_JALR:  begin cls = C_JALR;   imm32 = imm_i;  use_rs1 = 1'b1; end
            default:  ;
        endcase
    end

    assign imm_x     = XLEN'(signed'(imm32));
    assign writes_rd = cls inside {C_R, C_IALU, C_LOAD, C_LUI, C_AUIPC, C_JAL, C_JALR};

    // A write landing this cycle is forwarded and also retires any pending load on that register.
    assign hit1 = rf_wen && (rf_waddr == rs1);
    assign hit2 = rf_wen && (rf_waddr == rs2);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != '0) rs1_data = hit1 ? rf_wdata : regs_q[rs1];
        if (rs2 != '0) rs2_data = hit2 ? rf_wdata : regs_q[rs2];
    end

    assign hazard = in_valid &&
                    ((use_rs1 && (rs1 != '0) && pend_q[rs1] && !hit1) ||
                     (use_rs2 && (rs2 != '0) && pend_q[rs2] && !hit2));

    assign in_ready = rst && (!valid_q || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    always_comb begin
        new_b.rd      = rd;
        new_b.op      = opcode;
        new_b.f3      = instruction[14:12];
        new_b.op1     = rs1_data;
        new_b.op2     = (cls == C_R || cls == C_BRANCH) ? rs2_data : imm_x;
        new_b.sd      = rs2_data;
        new_b.imm     = imm_x;
        new_b.mem_wen = (cls == C_STORE);
        new_b.mem_ren = (cls == C_LOAD);
        new_b.rf_wen  = writes_rd && (rd != '0);
        new_b.illegal = (cls == C_ILLEGAL);
    end

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            bundle_d = new_b;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Clear is applied before set so a load capturing the same rd keeps it pending.
    always_comb begin
        pend_d = pend_q;
        if (rf_wen) pend_d[rf_waddr] = 1'b0;
        if (capture && cls == C_LOAD && rd != '0) pend_d[rd] = 1'b1;
    end

    always_comb begin
        regs_d = regs_q;
        if (rf_wen && rf_waddr != '0) regs_d[rf_waddr] = rf_wdata;
    end

    // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pend_q   <= '0;
            // NOTE: the register file is reset on purpose here; architectural state must read 0 after reset.
            regs_q   <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pend_q   <= pend_d;
            regs_q   <= regs_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_rdaddr     = bundle_q.rd;
    assign out_operation  = bundle_q.op;
    assign out_funct3     = bundle_q.f3;
    assign out_operand1   = bundle_q.op1;
    assign out_operand2   = bundle_q.op2;
    assign out_store_data = bundle_q.sd;
    assign out_imm        = bundle_q.imm;
    assign out_mem_wen    = bundle_q.mem_wen;
    assign out_mem_ren    = bundle_q.mem_ren;
    assign out_rf_wen     = bundle_q.rf_wen;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width in bits.
REQ-002 Parameter NREGS, default 32, register count; address width AW = clog2(NREGS).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_ready  output  1  stage accepts instruction this cycle.
REQ-007 instruction  input  32  RV32I instruction word.
REQ-008 flush  input  1  discard held output (synchronous).
REQ-009 rf_wen, rf_waddr, rf_wdata  input  1/AW/XLEN  writeback port.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts bundle.
REQ-012 out_rdaddr, out_operation, out_funct3  output  AW/7/3  destination, opcode, funct3.
REQ-013 out_operand1, out_operand2, out_store_data, out_imm  output  XLEN each  operands and extended immediate.
REQ-014 out_mem_wen, out_mem_ren, out_rf_wen, out_illegal  output  1 each  store, load, writes-rd, unknown opcode.

Function
REQ-015 Classes by opcode: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111; any other is illegal.
REQ-016 Immediate sign-extended to XLEN per format I, S, B (bit0=0), U (low 12 bits 0), J (bit0=0); R-type imm = 0.
REQ-017 operand2 = imm for I-ALU, load, store, LUI, AUIPC, JAL, JALR; = rs2 data for R and branch.
REQ-018 operand1 = rs1 data; store_data = rs2 data in all classes.
REQ-019 Register x0 reads 0 always; writes to x0 ignored.
REQ-020 Register file: NREGS x XLEN, written on clock edge when rf_wen=1 and rf_waddr!=0.
REQ-021 Write-through bypass: if rf_wen=1, rf_waddr!=0 and rf_waddr equals rs1/rs2 in the capture cycle, rf_wdata is captured instead of stored value.
REQ-022 out_rf_wen = 1 for R, I-ALU, load, LUI, AUIPC, JAL, JALR with rd!=0; 0 otherwise.
REQ-023 out_mem_ren = load class; out_mem_wen = store class.
REQ-024 Scoreboard: one pending bit per register; set for rd when a load with rd!=0 is captured; cleared on rf_wen to that address.
REQ-025 Same-cycle set and clear of same bit: set wins.
REQ-026 Hazard = in_valid and (rs1 pending or rs2 pending, used operands only, x0 never pending); a same-cycle clearing write removes the hazard.
REQ-027 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-028 Capture on in_valid & in_ready: bundle registered, out_valid=1 next cycle; latency 1 cycle.
REQ-029 out_valid & !out_ready: all out_* held stable.
REQ-030 out_valid & out_ready & no new capture: out_valid=0 next cycle.
REQ-031 flush=1: out_valid=0 next cycle, no capture; scoreboard unaffected.
REQ-032 Illegal: out_illegal=1, out_rf_wen/out_mem_wen/out_mem_ren=0, no scoreboard set; bundle still presented.

Reset
REQ-033 rst low: immediately out_valid=0, all out_* =0, scoreboard cleared, all registers =0; in_ready=0 while rst low.
REQ-034 Reset mid-stall or mid-hold discards the bundle; first capture possible first edge after rst high.

Verification
REQ-035 Reset, write x5=0x0000_0010, ADDI x6,x5,-1 (0xFFF28313) -> next cycle operand1=0x10, operand2=0xFFFF_FFFF, rdaddr=6, out_rf_wen=1.
REQ-036 LW x7,0(x1) accepted, then ADD x8,x7,x2 -> in_ready=0 until rf_wen to x7; same-cycle write of 0x55 -> ADD captured with operand1=0x55.
REQ-037 SW x3,8(x4) with x3=0xDEAD_BEEF -> out_mem_wen=1, operand2=8, store_data=0xDEAD_BEEF, out_rf_wen=0.
REQ-038 out_ready=0 for 3 cycles with valid bundle -> outputs unchanged, in_ready=0; flush -> out_valid=0 next cycle.
REQ-039 Opcode 0x7F, then BEQ x1,x2,-4 -> out_illegal=1 no writes; branch operand2=x2 data, out_imm=0xFFFF_FFFC.
